// File: rtl/sr_frame_pkg.sv
// Shared types and defaults for the framed-byte shift-register sequencer.
package sr_frame_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        StHunt,
        StCmd,
        StPayload,
        StClose
    } parse_state_e;

    localparam byte_t       FLAG_DEFAULT    = 8'h7E;
    localparam int unsigned MAX_LEN_DEFAULT = 8;

endpackage

// File: rtl/sr_frame_sequencer_fifo.sv
// Small synchronous byte FIFO with first-word-fall-through read data.
module sr_byte_fifo
    import sr_frame_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic  i_clk,
    input  logic  i_rst_n,
    input  logic  i_push,
    input  byte_t i_data,
    input  logic  i_pop,
    output byte_t o_data,
    output logic  o_full,
    output logic  o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

    byte_t         r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == FullCnt);
    assign o_empty   = (r_count == '0);
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    // A pop in the same cycle frees the slot, so a push at full is still taken.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_do_push && !w_do_pop)      r_count <= r_count + (AW + 1)'(1);
            else if (!w_do_push && w_do_pop) r_count <= r_count - (AW + 1)'(1);
        end
    end

endmodule

// File: rtl/sr_frame_sequencer.sv
// Parses FLAG/COUNT/payload/FLAG frames, shifts payload MSB-first into an external
// shift register and latches only after a correctly closed frame has drained.
module sr_frame_sequencer
    import sr_frame_pkg::*;
#(
    parameter int unsigned SHIFT_DIV  = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MAX_LEN    = MAX_LEN_DEFAULT,
    parameter byte_t       FLAG       = FLAG_DEFAULT
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       sr_dout,
    output logic       sr_shift,
    output logic       sr_latch,
    output logic [7:0] led,
    output logic       busy,
    output logic       frame_err,
    output logic       ovf
);

    localparam int unsigned DW      = $clog2(SHIFT_DIV);
    localparam logic [DW-1:0] DivLast = DW'(SHIFT_DIV - 1);
    localparam byte_t       MaxLenB = byte_t'(MAX_LEN);

    parse_state_e r_state, w_state_d;
    byte_t        r_cnt, r_rcv, r_last_byte, r_led_next, r_led, r_sh_byte;
    logic         r_frame_err, r_ovf, r_latch_pending, r_active;
    logic [DW-1:0] r_div;
    logic [2:0]   r_bit;

    logic  w_push, w_err, w_close, w_load_cnt, w_rcv_inc;
    logic  w_pop, w_full, w_empty, w_sh_done, w_bit_end, w_latch;
    byte_t w_fifo_data, w_rcv_next;

    assign w_rcv_next = r_rcv + 8'd1;

    always_comb begin
        w_state_d  = r_state;
        w_push     = 1'b0;
        w_err      = 1'b0;
        w_close    = 1'b0;
        w_load_cnt = 1'b0;
        w_rcv_inc  = 1'b0;
        if (rx_valid) begin
            unique case (r_state)
                StHunt: begin
                    if (rx_data == FLAG) w_state_d = StCmd;
                end
                StCmd: begin
                    if (rx_data == FLAG) begin
                        w_state_d = StCmd;
                    end else if (rx_data != 8'd0 && rx_data <= MaxLenB) begin
                        w_load_cnt = 1'b1;
                        w_state_d  = StPayload;
                    end else begin
                        w_err     = 1'b1;
                        w_state_d = StHunt;
                    end
                end
                StPayload: begin
                    // No escaping: a FLAG here is always an early delimiter.
                    if (rx_data == FLAG) begin
                        w_err     = 1'b1;
                        w_state_d = StCmd;
                    end else begin
                        w_push    = 1'b1;
                        w_rcv_inc = 1'b1;
                        if (w_rcv_next == r_cnt) w_state_d = StClose;
                    end
                end
                StClose: begin
                    if (rx_data == FLAG) begin
                        w_close   = 1'b1;
                        w_state_d = StCmd;
                    end else begin
                        w_err     = 1'b1;
                        w_state_d = StHunt;
                    end
                end
                default: w_state_d = StHunt;
            endcase
        end
    end

    sr_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst_n (reset),
        .i_push  (w_push),
        .i_data  (rx_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_bit_end = r_active && (r_div == DivLast);
    assign w_sh_done = w_bit_end && (r_bit == 3'd7);
    assign w_pop     = !w_empty && (!r_active || w_sh_done);
    assign w_latch   = r_latch_pending && w_empty && !r_active;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state         <= StHunt;
            r_cnt           <= '0;
            r_rcv           <= '0;
            r_last_byte     <= '0;
            r_led_next      <= '0;
            r_led           <= '0;
            r_frame_err     <= 1'b0;
            r_ovf           <= 1'b0;
            r_latch_pending <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_frame_err <= w_err;
            if (w_load_cnt) begin
                r_cnt <= rx_data;
                r_rcv <= '0;
            end
            if (w_rcv_inc) begin
                r_rcv       <= w_rcv_next;
                r_last_byte <= rx_data;
            end
            if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
            if (w_latch) r_led <= r_led_next;
            // A close that coincides with a latch re-arms for the newer frame.
            if (w_close) begin
                r_latch_pending <= 1'b1;
                r_led_next      <= r_last_byte;
            end else if (w_latch) begin
                r_latch_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_active  <= 1'b0;
            r_sh_byte <= '0;
            r_div     <= '0;
            r_bit     <= '0;
        end else if (w_pop) begin
            r_active  <= 1'b1;
            r_sh_byte <= w_fifo_data;
            r_div     <= '0;
            r_bit     <= '0;
        end else if (r_active) begin
            if (w_bit_end) begin
                r_div     <= '0;
                r_sh_byte <= {r_sh_byte[6:0], 1'b0};
                if (r_bit == 3'd7) r_active <= 1'b0;
                else               r_bit    <= r_bit + 3'd1;
            end else begin
                r_div <= r_div + DW'(1);
            end
        end
    end

    assign sr_dout   = r_active && r_sh_byte[7];
    assign sr_shift  = w_bit_end;
    assign sr_latch  = w_latch;
    assign led       = r_led;
    assign frame_err = r_frame_err;
    assign ovf       = r_ovf;
    assign busy      = (r_state == StPayload) || (r_state == StClose) || !w_empty ||
                       r_active || r_latch_pending;

endmodule

// File: tb/tb_sr_frame_sequencer.sv
// Directed, table-driven bench for sr_frame_sequencer with default parameters.
module tb_sr_frame_sequencer;

    logic       CLK = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       sr_dout, sr_shift, sr_latch, busy, frame_err, ovf;
    logic [7:0] led;

    sr_frame_sequencer dut (
        .CLK       (CLK),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .sr_dout   (sr_dout),
        .sr_shift  (sr_shift),
        .sr_latch  (sr_latch),
        .led       (led),
        .busy      (busy),
        .frame_err (frame_err),
        .ovf       (ovf)
    );

    always #5 CLK = ~CLK;

    int          n_shift = 0;
    int          n_latch = 0;
    int          n_ferr  = 0;
    logic [63:0] mon_bits = '0;

    always @(negedge CLK) begin
        if (sr_shift) begin
            n_shift  <= n_shift + 1;
            mon_bits <= {mon_bits[62:0], sr_dout};
        end
        if (sr_latch)  n_latch <= n_latch + 1;
        if (frame_err) n_ferr  <= n_ferr + 1;
    end

    typedef struct {
        logic [95:0] data;
        int          n;
        int          shifts;
        int          latches;
        int          errs;
        logic [7:0]  led;
        logic [63:0] bits;
        int          nbits;
    } vec_t;

    vec_t vecs [7];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at posedge+1; gap=0 strobes the next byte on the very next cycle.
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge CLK); #1;
        rx_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(posedge CLK); #1;
        end
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 3000; i++) begin
            if (!busy) break;
            @(posedge CLK); #1;
        end
        check({name, "_drain"}, 64'(busy), 64'd0);
        @(posedge CLK); #1;
    endtask

    int s0, l0, e0, busy_low, got_latch;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{96'hF4_7E_03_55_57_FE_7E, 7, 24, 1, 0, 8'hFE, 64'h5557FE, 24};
        vecs[1] = '{96'h7E_00, 2, 0, 0, 1, 8'hFE, 64'h0, 0};
        vecs[2] = '{96'h41_7E_06_C0_F0_FE_FE_FC_FF_7E, 10, 48, 1, 0, 8'hFF,
                    64'hC0F0FEFEFCFF, 48};
        vecs[3] = '{96'h7E_09, 2, 0, 0, 1, 8'hFF, 64'h0, 0};
        vecs[4] = '{96'h01_55_7E, 3, 0, 0, 0, 8'hFF, 64'h0, 0};
        vecs[5] = '{96'h7E_03_11_22_7E, 5, 16, 0, 1, 8'hFF, 64'h1122, 16};
        vecs[6] = '{96'h01_AA_7E, 3, 8, 1, 0, 8'hAA, 64'hAA, 8};

        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_outputs", 64'({sr_dout, sr_shift, sr_latch, led, busy, frame_err, ovf}),
              64'd0);
        reset = 1'b1;
        @(posedge CLK); #1;

        for (int v = 0; v < 7; v++) begin
            s0 = n_shift; l0 = n_latch; e0 = n_ferr;
            for (int i = 0; i < vecs[v].n; i++) begin
                send_byte(vecs[v].data[8*(vecs[v].n-1-i) +: 8], 40);
            end
            wait_idle($sformatf("v%0d", v));
            check($sformatf("v%0d_shifts", v), 64'(n_shift - s0), 64'(vecs[v].shifts));
            check($sformatf("v%0d_latches", v), 64'(n_latch - l0), 64'(vecs[v].latches));
            check($sformatf("v%0d_frame_err", v), 64'(n_ferr - e0), 64'(vecs[v].errs));
            check($sformatf("v%0d_led", v), 64'(led), 64'(vecs[v].led));
            if (vecs[v].nbits > 0) begin
                check($sformatf("v%0d_bits", v),
                      mon_bits & ((64'd1 << vecs[v].nbits) - 64'd1), vecs[v].bits);
            end
        end

        // Overflow: eight payload bytes strobed on consecutive cycles into a 4-deep FIFO.
        check("ovf_pre", 64'(ovf), 64'd0);
        s0 = n_shift; l0 = n_latch; e0 = n_ferr;
        send_byte(8'h7E, 2);
        send_byte(8'h08, 0);
        for (int i = 0; i < 8; i++) send_byte(8'h81 + 8'(i), 0);
        send_byte(8'h7E, 0);
        busy_low  = 0;
        got_latch = 0;
        for (int i = 0; i < 1000; i++) begin
            if (sr_latch) begin
                got_latch = 1;
                break;
            end
            if (!busy) busy_low++;
            @(posedge CLK); #1;
        end
        check("ovf_set", 64'(ovf), 64'd1);
        check("ovf_latch_seen", 64'(got_latch), 64'd1);
        check("ovf_busy_held", 64'(busy_low), 64'd0);
        wait_idle("ovf");
        check("ovf_shifts", 64'(n_shift - s0), 64'd40);
        check("ovf_latches", 64'(n_latch - l0), 64'd1);
        check("ovf_frame_err", 64'(n_ferr - e0), 64'd0);
        check("ovf_led", 64'(led), 64'h88);

        // Reset in the middle of shifting an all-ones byte.
        send_byte(8'h7E, 2);
        send_byte(8'h01, 2);
        send_byte(8'hFF, 0);
        for (int i = 0; i < 50; i++) begin
            if (sr_dout) break;
            @(posedge CLK); #1;
        end
        check("rst_dout_pre", 64'(sr_dout), 64'd1);
        repeat (4) @(posedge CLK);
        #2;
        reset = 1'b0;
        #1;
        check("rst_async_outputs",
              64'({sr_dout, sr_shift, sr_latch, led, busy, frame_err, ovf}), 64'd0);
        repeat (2) @(posedge CLK);
        #1;
        reset = 1'b1;
        s0 = n_shift; l0 = n_latch; e0 = n_ferr;
        send_byte(8'h7E, 40);
        send_byte(8'h01, 40);
        send_byte(8'h3C, 40);
        send_byte(8'h7E, 40);
        wait_idle("post_rst");
        check("post_rst_shifts", 64'(n_shift - s0), 64'd8);
        check("post_rst_latches", 64'(n_latch - l0), 64'd1);
        check("post_rst_frame_err", 64'(n_ferr - e0), 64'd0);
        check("post_rst_led", 64'(led), 64'h3C);
        check("post_rst_bits", mon_bits & 64'hFF, 64'h3C);

        $display("Result: errors=%0d of %0d checks", n_fail, n_checks);
        $finish;
    end

endmodule
